// File: rtl/ra_cfg_loader_pkg.sv
// Shared definitions for the array-local config loader: widths, FSM state
// encoding, error-flag bundle and a bit-counter helper.
package ra_pkg;

  localparam int CFG_W     = 32;
  localparam int CNT_W     = 8;
  localparam int BIT_CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    PAR,
    STOP,
    WRITE
  } state_t;

  typedef struct packed {
    logic par;
    logic frm;
    logic adr;
  } err_t;

  // True when the bit being sampled is the final one of a field of `len` bits.
  function automatic logic last_bit(input logic [BIT_CNT_W-1:0] cnt,
                                    input int unsigned len);
    return cnt == BIT_CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/ra_cfg_loader_if.sv
// Serial config port plus the shared write bus towards the ra_cfg targets.
// The loader uses the master view; whatever feeds the frames and watches the bus uses slave.
interface ra_cfg_loader_if
  import ra_pkg::*;
#(
  parameter int NUM_TGT = 8
) ();

  logic               sen;
  logic               sdi;
  logic [NUM_TGT-1:0] cfg_wr;
  logic [0:CFG_W-1]   cfg_dat;

  modport master (
    input  sen,
    input  sdi,
    output cfg_wr,
    output cfg_dat
  );

  modport slave (
    output sen,
    output sdi,
    input  cfg_wr,
    input  cfg_dat
  );

endinterface

// File: rtl/ra_cfg_shift.sv
// Frame datapath: shifts address+data bits in arrival order, counts bits
// within the current field and keeps the running even-parity of everything shifted.
module ra_cfg_shift
  import ra_pkg::*;
#(
  parameter int SR_W = CFG_W + 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 shift,
  input  logic                 cnt_clr,
  input  logic                 bit_in,
  output logic [0:SR_W-1]      word,
  output logic [BIT_CNT_W-1:0] cnt,
  output logic                 par
);

  // First bit received ends up in word[0], so the address MSB lands leftmost
  // and cfg_dat bit 0 sits directly after the address field.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the shift register is reset like the rest so a frame aborted by
      // reset can never leave stale bits that look like a decoded word.
      word <= '0;
      cnt  <= '0;
      par  <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      par <= 1'b0;
    end else if (shift) begin
      // NOTE: non-blocking assignments, so word, par and cnt all update from
      // their pre-edge values regardless of statement order.
      word <= {word[1:SR_W-1], bit_in};
      par  <= par ^ bit_in;
      cnt  <= cnt_clr ? '0 : cnt + BIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/ra_cfg_loader.sv
// Serial-to-parallel config initiator: decodes framed writes on sdi/sen and
// drives one-hot cfg_wr strobes plus a shared cfg_dat word to NUM_TGT ra_cfg targets.
module ra_cfg_loader
  import ra_pkg::*;
#(
  parameter int NUM_TGT = 8,
  parameter int ADDR_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  ra_cfg_loader_if.master      bus,
  input  logic                 clr_err,
  output logic                 busy,
  output logic                 err_par,
  output logic                 err_frm,
  output logic                 err_adr,
  output logic [CNT_W-1:0]     wr_cnt
);

  localparam int SR_W = ADDR_W + CFG_W;
  localparam logic [ADDR_W:0] TGT_LIM = (ADDR_W + 1)'(NUM_TGT);

  state_t               state;
  logic                 par_bad;
  err_t                 err_q;
  err_t                 frame_err;
  logic [NUM_TGT-1:0]   cfg_wr_q;
  logic [0:CFG_W-1]     cfg_dat_q;

  logic [0:SR_W-1]      word;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 par_acc;

  logic                 sen;
  logic                 sdi;
  logic                 frame_start;
  logic                 bit_take;
  logic                 addr_last;
  logic                 data_last;
  logic [ADDR_W-1:0]    addr;
  logic [0:CFG_W-1]     data;
  logic                 adr_ok;

  assign sen = bus.sen;
  assign sdi = bus.sdi;

  assign frame_start = (state == IDLE) && sen && !sdi;
  assign bit_take    = sen && ((state == ADDR) || (state == DATA));
  assign addr_last   = sen && (state == ADDR) && last_bit(bit_cnt, ADDR_W);
  assign data_last   = sen && (state == DATA) && last_bit(bit_cnt, CFG_W);

  ra_cfg_shift #(
    .SR_W (SR_W)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .start   (frame_start),
    .shift   (bit_take),
    .cnt_clr (addr_last || data_last),
    .bit_in  (sdi),
    .word    (word),
    .cnt     (bit_cnt),
    .par     (par_acc)
  );

  assign addr   = word[0:ADDR_W-1];
  assign data   = word[ADDR_W +: CFG_W];
  assign adr_ok = {1'b0, addr} < TGT_LIM;

  // Checks evaluated on the stop-bit sample; several may fail at once.
  always_comb begin
    // NOTE: default assignment first, so every path drives frame_err and no latch is inferred.
    frame_err     = '0;
    frame_err.par = par_bad;
    frame_err.frm = !sdi;
    frame_err.adr = !adr_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      par_bad   <= 1'b0;
      err_q     <= '0;
      cfg_wr_q  <= '0;
      cfg_dat_q <= '0;
      wr_cnt    <= '0;
    end else begin
      cfg_wr_q <= '0;
      if (clr_err) err_q <= '0;

      unique case (state)
        IDLE: begin
          if (frame_start) state <= ADDR;
        end
        ADDR: begin
          if (addr_last) state <= DATA;
        end
        DATA: begin
          if (data_last) state <= PAR;
        end
        PAR: begin
          if (sen) begin
            par_bad <= par_acc ^ sdi;
            state   <= STOP;
          end
        end
        STOP: begin
          if (sen) begin
            if (frame_err == '0) begin
              state     <= WRITE;
              cfg_wr_q  <= NUM_TGT'(1) << addr;
              cfg_dat_q <= data;
              wr_cnt    <= wr_cnt + CNT_W'(1);
            end else begin
              state <= IDLE;
              // A new error in the same cycle as clr_err must survive the clear.
              err_q <= (clr_err ? err_t'('0) : err_q) | frame_err;
            end
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_wr  = cfg_wr_q;
  assign bus.cfg_dat = cfg_dat_q;
  assign busy        = (state != IDLE);
  assign err_par     = err_q.par;
  assign err_frm     = err_q.frm;
  assign err_adr     = err_q.adr;

endmodule

// File: tb/tb_ra_cfg_loader.sv
// Scoreboard bench: two loaders (8 and 6 targets) share one serial line; frames
// push expected strobes into per-DUT queues, a negedge monitor pops and compares.
module tb_ra_cfg_loader;
  import ra_pkg::*;

  typedef struct {
    logic [7:0]  wr;
    logic [31:0] dat;
    logic [7:0]  cnt;
  } exp_t;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic clr_err = 1'b0;
  logic sen     = 1'b0;
  logic sdi     = 1'b1;

  always #5 clk = ~clk;

  ra_cfg_loader_if #(.NUM_TGT(8)) bus8 ();
  ra_cfg_loader_if #(.NUM_TGT(6)) bus6 ();

  assign bus8.sen = sen;
  assign bus8.sdi = sdi;
  assign bus6.sen = sen;
  assign bus6.sdi = sdi;

  logic       busy8, ep8, ef8, ea8;
  logic       busy6, ep6, ef6, ea6;
  logic [7:0] cnt8, cnt6;

  ra_cfg_loader #(.NUM_TGT(8), .ADDR_W(3)) dut8 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus8.master),
    .clr_err (clr_err),
    .busy    (busy8),
    .err_par (ep8),
    .err_frm (ef8),
    .err_adr (ea8),
    .wr_cnt  (cnt8)
  );

  ra_cfg_loader #(.NUM_TGT(6), .ADDR_W(3)) dut6 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus6.master),
    .clr_err (clr_err),
    .busy    (busy6),
    .err_par (ep6),
    .err_frm (ef6),
    .err_adr (ea6),
    .wr_cnt  (cnt6)
  );

  logic [1:0]  busy_v, ep_v, ef_v, ea_v;
  logic [7:0]  cnt_v [2];
  logic [7:0]  wr_v  [2];
  logic [31:0] dat_v [2];

  assign busy_v = {busy6, busy8};
  assign ep_v   = {ep6, ep8};
  assign ef_v   = {ef6, ef8};
  assign ea_v   = {ea6, ea8};
  assign cnt_v  = '{cnt8, cnt6};
  assign wr_v   = '{bus8.cfg_wr, {2'b00, bus6.cfg_wr}};
  assign dat_v  = '{bus8.cfg_dat, bus6.cfg_dat};

  int          ntgt [2] = '{8, 6};
  logic [7:0]  m_cnt [2];
  logic [31:0] m_dat [2];
  logic        m_ep [2], m_ef [2], m_ea [2];
  exp_t        q0 [$];
  exp_t        q1 [$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every strobe cycle must match the oldest pending expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_v[d] !== 8'h00) begin
        if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          check($sformatf("dut%0d_unexpected_strobe", d), 64'(wr_v[d]), 64'h0);
        end else begin
          exp_t e;
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("dut%0d_strobe_wr", d),  64'(wr_v[d]),  64'(e.wr));
          check($sformatf("dut%0d_strobe_dat", d), 64'(dat_v[d]), 64'(e.dat));
          check($sformatf("dut%0d_strobe_cnt", d), 64'(cnt_v[d]), 64'(e.cnt));
        end
      end
    end
  end

  task automatic check_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_dut%0d_busy", tag, d),    64'(busy_v[d]), 64'h0);
      check($sformatf("%s_dut%0d_cfg_wr", tag, d),  64'(wr_v[d]),   64'h0);
      check($sformatf("%s_dut%0d_cfg_dat", tag, d), 64'(dat_v[d]),  64'(m_dat[d]));
      check($sformatf("%s_dut%0d_wr_cnt", tag, d),  64'(cnt_v[d]),  64'(m_cnt[d]));
      check($sformatf("%s_dut%0d_err_par", tag, d), 64'(ep_v[d]),   64'(m_ep[d]));
      check($sformatf("%s_dut%0d_err_frm", tag, d), 64'(ef_v[d]),   64'(m_ef[d]));
      check($sformatf("%s_dut%0d_err_adr", tag, d), 64'(ea_v[d]),   64'(m_ea[d]));
      check($sformatf("%s_dut%0d_pending", tag, d),
            64'((d == 0) ? q0.size() : q1.size()), 64'h0);
    end
  endtask

  task automatic model_clear_err();
    for (int d = 0; d < 2; d++) begin
      m_ep[d] = 1'b0;
      m_ef[d] = 1'b0;
      m_ea[d] = 1'b0;
    end
  endtask

  // Caller has already pulled reset low (or it is being pulled here).
  task automatic do_reset(input string tag);
    reset = 1'b0;
    sen   = 1'b0;
    sdi   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    q0.delete();
    q1.delete();
    model_clear_err();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 8'h00;
      m_dat[d] = 32'h0;
    end
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic pulse_clr(input string tag);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    model_clear_err();
    check_state(tag);
  endtask

  // Frame: start, 3 address bits MSB first, 32 data bits (cfg_dat bit 0 =
  // literal MSB first), even parity over addr+data, stop.
  task automatic send_frame(input string tag, input logic [2:0] addr, input logic [31:0] data,
                            input bit flip_par, input logic stop_bit, input bit toggle,
                            input bit hold_clr, input int abort_at);
    logic bits [38];
    int   last;
    int   busy_drop;
    bits[0] = 1'b0;
    for (int i = 0; i < 3; i++)  bits[1 + i] = addr[2 - i];
    for (int j = 0; j < 32; j++) bits[4 + j] = data[31 - j];
    bits[36] = (^{addr, data}) ^ flip_par;
    bits[37] = stop_bit;

    if (abort_at < 0) begin
      if (hold_clr) model_clear_err();
      for (int d = 0; d < 2; d++) begin
        logic ok;
        ok = !flip_par && stop_bit && (int'(addr) < ntgt[d]);
        if (ok) begin
          exp_t e;
          m_cnt[d] = m_cnt[d] + 8'h01;
          m_dat[d] = data;
          e.wr  = 8'h01 << addr;
          e.dat = data;
          e.cnt = m_cnt[d];
          if (d == 0) q0.push_back(e);
          else        q1.push_back(e);
        end else begin
          m_ep[d] = m_ep[d] | flip_par;
          m_ef[d] = m_ef[d] | !stop_bit;
          m_ea[d] = m_ea[d] | (int'(addr) >= ntgt[d]);
        end
      end
    end

    last      = (abort_at >= 0) ? abort_at : 37;
    busy_drop = 0;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      if (i > 0 && busy_v != 2'b11) busy_drop++;
      sen = 1'b1;
      sdi = bits[i];
      if (i == 37 && hold_clr) clr_err = 1'b1;
      if (toggle) begin
        @(negedge clk);
        if (i < 37 && busy_v != 2'b11) busy_drop++;
        sen     = 1'b0;
        sdi     = ~bits[i];
        clr_err = 1'b0;
      end
    end
    if (abort_at >= 0) return;

    @(negedge clk);
    sen     = 1'b0;
    sdi     = 1'b1;
    clr_err = 1'b0;
    @(negedge clk);
    check({tag, "_busy_frame"}, 64'(busy_drop), 64'h0);
    check_state(tag);
  endtask

  initial begin
    #1 reset = 1'b0;
    do_reset("reset");

    send_frame("good_a5", 3'd5, 32'hA5A5_0F0F, 1'b0, 1'b1, 1'b0, 1'b0, -1);

    send_frame("bad_par", 3'd5, 32'hA5A5_0F0F, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    pulse_clr("clr_par");

    send_frame("adr7_stop0", 3'd7, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    pulse_clr("clr_frm_adr");

    send_frame("adr6", 3'd6, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    send_frame("adr7_clr_same", 3'd7, 32'h0000_8001, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    pulse_clr("clr_adr");

    send_frame("sen_toggle", 3'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, -1);

    send_frame("abort", 3'd1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b0, 21);
    @(posedge clk);
    #2;
    do_reset("mid_reset");
    send_frame("after_reset", 3'd1, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, -1);

    for (int k = 1; k < 256; k++) begin
      send_frame("wrap_run", 3'(k % 6), 32'(k) * 32'h9E37_79B1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    end
    check("dut0_wr_cnt_wrap", 64'(cnt8), 64'h0);
    check("dut1_wr_cnt_wrap", 64'(cnt6), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

endmodule
